// File: rtl/mp_cmd_rx_pkg.sv
// -----------------------------------------------------------------------------
// mp_cmd_rx_pkg
// Shared constants and types for the per-core message-passing command receiver.
//   MP_PC_W / MP_DATA_W : default widths of the hub's command PC and data fields
//   MP_RX_DEPTH         : default receive FIFO depth
//   ack_state_t         : acknowledge FSM state encoding
// -----------------------------------------------------------------------------
package mp_cmd_rx_pkg;

  localparam int MP_PC_W     = 14;
  localparam int MP_DATA_W   = 32;
  localparam int MP_RX_DEPTH = 4;

  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_BUSY = 1'b1
  } ack_state_t;

endpackage

// File: rtl/mp_cmd_rx_fifo.sv
// -----------------------------------------------------------------------------
// mp_cmd_fifo
// First-word-fall-through synchronous FIFO holding {pc, data} commands.
//   clk, rstn       : clock, asynchronous active-low reset (clears contents)
//   push, push_data : write push_data at the tail on the rising edge
//   pop             : retire the head on the rising edge (ignored when empty)
//   head_data       : current head entry, driven straight from storage
//   not_empty       : head is valid
//   level, full     : registered occupancy and occupancy == DEPTH
// -----------------------------------------------------------------------------
module mp_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 46
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             push_eff;
  logic             pop_eff;

  // A pop on an empty FIFO is dropped; a push into a full FIFO is only legal
  // when a pop frees the slot in the same cycle.
  assign pop_eff  = pop & (level_q != '0);
  assign push_eff = push & ((level_q != FULL_LVL) | pop_eff);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_eff) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_eff, pop_eff})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Stale head is presented when empty; consumers qualify with not_empty.
  assign head_data = mem[rd_ptr];
  assign not_empty = (level_q != '0);
  assign level     = level_q;
  assign full      = (level_q == FULL_LVL);

endmodule

// File: rtl/mp_cmd_rx.sv
// -----------------------------------------------------------------------------
// mp_cmd_rx
// Per-core receiver for message-passing commands from the mp hub. Accepts a
// command, acknowledges it for one cycle, queues {pc, data} and offers the
// queue head to the thread unit as a handler-launch request.
//   clk, rstn          : clock, asynchronous active-low reset
//   mp_access          : hub command valid (hub masks it with our ack)
//   mp_command_pc/data : command fields, held stable by the hub until acked
//   mp_access_ack      : registered one-cycle acknowledge
//   rx_enable          : 0 blocks new accepts; queue still drains
//   launch_valid/pc/data, launch_ready : FWFT head handshake to thread unit
//   rx_level, rx_full  : registered occupancy / full flag
// -----------------------------------------------------------------------------
module mp_cmd_rx
  import mp_cmd_rx_pkg::*;
#(
  parameter int DEPTH  = MP_RX_DEPTH,
  parameter int PC_W   = MP_PC_W,
  parameter int DATA_W = MP_DATA_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   mp_access,
  input  logic [PC_W-1:0]        mp_command_pc,
  input  logic [DATA_W-1:0]      mp_command_data,
  output logic                   mp_access_ack,
  input  logic                   rx_enable,
  output logic                   launch_valid,
  output logic [PC_W-1:0]        launch_pc,
  output logic [DATA_W-1:0]      launch_data,
  input  logic                   launch_ready,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   rx_full
);

  ack_state_t              ack_state;
  logic                    pop;
  logic                    acc;
  logic [PC_W+DATA_W-1:0]  head;

  assign pop = launch_valid & launch_ready;

  // Never accept while acking, so a command the hub has not yet retired cannot
  // be captured twice; a same-cycle pop makes room in a full queue.
  assign acc = mp_access & ~mp_access_ack & rx_enable & (~rx_full | pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_state     <= ACK_IDLE;
      mp_access_ack <= 1'b0;
    end else begin
      case (ack_state)
        ACK_IDLE: begin
          if (acc) begin
            ack_state     <= ACK_BUSY;
            mp_access_ack <= 1'b1;
          end
        end
        ACK_BUSY: begin
          ack_state     <= ACK_IDLE;
          mp_access_ack <= 1'b0;
        end
        default: begin
          ack_state     <= ACK_IDLE;
          mp_access_ack <= 1'b0;
        end
      endcase
    end
  end

  mp_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (acc),
    .push_data ({mp_command_pc, mp_command_data}),
    .pop       (pop),
    .head_data (head),
    .not_empty (launch_valid),
    .level     (rx_level),
    .full      (rx_full)
  );

  assign launch_pc   = head[PC_W+DATA_W-1:DATA_W];
  assign launch_data = head[DATA_W-1:0];

endmodule

// File: tb/tb_mp_cmd_rx.sv
module tb_mp_cmd_rx;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 14;
  localparam int DATA_W = 32;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   hub_req;
  logic                   mp_access;
  logic [PC_W-1:0]        hub_pc;
  logic [DATA_W-1:0]      hub_data;
  logic                   mp_access_ack;
  logic                   rx_enable;
  logic                   launch_valid;
  logic [PC_W-1:0]        launch_pc;
  logic [DATA_W-1:0]      launch_data;
  logic                   launch_ready;
  logic [$clog2(DEPTH):0] rx_level;
  logic                   rx_full;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acks  = 0;

  // Hub behaviour: command valid is masked by our acknowledge.
  assign mp_access = hub_req & ~mp_access_ack;

  mp_cmd_rx #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .mp_access       (mp_access),
    .mp_command_pc   (hub_pc),
    .mp_command_data (hub_data),
    .mp_access_ack   (mp_access_ack),
    .rx_enable       (rx_enable),
    .launch_valid    (launch_valid),
    .launch_pc       (launch_pc),
    .launch_data     (launch_data),
    .launch_ready    (launch_ready),
    .rx_level        (rx_level),
    .rx_full         (rx_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of commands plus the pending-ack flag.
  cmd_t q[$];
  bit   m_ack = 1'b0;
  bit   prev_ack = 1'b0;

  always @(negedge clk) begin
    bit pop_m;
    bit acc_m;
    cmd_t e;
    if (!rstn) begin
      q.delete();
      m_ack    = 1'b0;
      prev_ack = 1'b0;
      chk("m_rst_ack",   64'(mp_access_ack), 64'(0));
      chk("m_rst_valid", 64'(launch_valid),  64'(0));
      chk("m_rst_level", 64'(rx_level),      64'(0));
      chk("m_rst_full",  64'(rx_full),       64'(0));
    end else begin
      chk("m_ack",   64'(mp_access_ack), 64'(m_ack));
      chk("m_valid", 64'(launch_valid),  64'(q.size() != 0));
      chk("m_level", 64'(rx_level),      64'(q.size()));
      chk("m_full",  64'(rx_full),       64'(q.size() == DEPTH));
      if (q.size() != 0) begin
        chk("m_head_pc",   64'(launch_pc),   64'(q[0].pc));
        chk("m_head_data", 64'(launch_data), 64'(q[0].data));
      end
      if (mp_access_ack) begin
        acks++;
        chk("no_double_ack", 64'(prev_ack), 64'(0));
      end
      prev_ack = mp_access_ack;
      // Next state from the accept/pop rules applied to this cycle's inputs.
      pop_m = (q.size() != 0) && launch_ready;
      acc_m = mp_access && !m_ack && rx_enable && ((q.size() < DEPTH) || pop_m);
      if (pop_m) void'(q.pop_front());
      if (acc_m) begin
        e.pc   = hub_pc;
        e.data = hub_data;
        q.push_back(e);
      end
      m_ack = acc_m;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until acknowledged; returns in the ack cycle.
  task automatic send(input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] data);
    bit ok = 1'b0;
    hub_pc   = pc;
    hub_data = data;
    hub_req  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mp_access_ack) begin
        ok = 1'b1;
        break;
      end
    end
    hub_req = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=noack want=ack pc=%0h", pc);
    end
  endtask

  task automatic drain();
    launch_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!launch_valid) break;
      tick();
    end
    launch_ready = 1'b0;
    chk("drain_empty", 64'(launch_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nack;
    int got;
    int start_cyc;
    int start_acks;

    rstn = 1'b0; hub_req = 1'b0; hub_pc = '0; hub_data = '0;
    rx_enable = 1'b1; launch_ready = 1'b0;
    repeat (2) tick();
    chk("rst_ack",   64'(mp_access_ack), 64'(0));
    chk("rst_valid", 64'(launch_valid),  64'(0));
    chk("rst_level", 64'(rx_level),      64'(0));
    chk("rst_full",  64'(rx_full),       64'(0));
    rstn = 1'b1;
    tick();

    // Single command
    send(14'h0123, 32'hDEADBEEF);
    chk("t1_ack",   64'(mp_access_ack), 64'(1));
    chk("t1_valid", 64'(launch_valid),  64'(1));
    chk("t1_pc",    64'(launch_pc),     64'h0123);
    chk("t1_data",  64'(launch_data),   64'hDEADBEEF);
    chk("t1_level", 64'(rx_level),      64'(1));
    tick();
    chk("t1_ack_drop", 64'(mp_access_ack), 64'(0));
    drain();

    // Fill, then a held fifth command that gets in on the first pop
    for (int k = 1; k <= 4; k++) send(14'(k), 32'h100 + 32'(k));
    tick();
    chk("t2_full",  64'(rx_full),  64'(1));
    chk("t2_level", 64'(rx_level), 64'(4));
    hub_pc = 14'd5; hub_data = 32'h105; hub_req = 1'b1;
    nack = 0;
    repeat (4) begin
      tick();
      nack += int'(mp_access_ack);
    end
    chk("t2_no_ack_full", 64'(nack), 64'(0));
    chk("t2_head1", 64'(launch_pc), 64'(1));
    launch_ready = 1'b1;
    tick();
    launch_ready = 1'b0;
    got = int'(mp_access_ack);
    if (got == 0) begin
      tick();
      got = int'(mp_access_ack);
    end
    hub_req = 1'b0;
    chk("t2_fifth_ack", 64'(got), 64'(1));
    for (int k = 2; k <= 5; k++) begin
      chk("t2_order", 64'(launch_pc), 64'(k));
      launch_ready = 1'b1;
      tick();
      launch_ready = 1'b0;
    end
    chk("t2_empty", 64'(launch_valid), 64'(0));

    // Simultaneous push and pop at level 2, pointers wrap
    send(14'h2A, 32'd100);
    send(14'h2B, 32'd101);
    tick();
    for (int i = 0; i < 10; i++) begin
      hub_pc = 14'(i); hub_data = 32'(i); hub_req = 1'b1; launch_ready = 1'b1;
      tick();
      hub_req = 1'b0; launch_ready = 1'b0;
      chk("t3_ack",   64'(mp_access_ack), 64'(1));
      chk("t3_level", 64'(rx_level),      64'(2));
      tick();
    end
    chk("t3_head_data", 64'(launch_data), 64'(8));
    drain();

    // rx_enable low blocks accepts
    rx_enable = 1'b0;
    hub_pc = 14'h3C; hub_data = 32'hCAFE0004; hub_req = 1'b1;
    nack = 0;
    repeat (3) begin
      tick();
      nack += int'(mp_access_ack);
    end
    chk("t4_no_ack", 64'(nack),     64'(0));
    chk("t4_level0", 64'(rx_level), 64'(0));
    rx_enable = 1'b1;
    tick();
    chk("t4_ack", 64'(mp_access_ack), 64'(1));
    hub_req = 1'b0;
    tick();
    chk("t4_level1",    64'(rx_level),      64'(1));
    chk("t4_ack_drop",  64'(mp_access_ack), 64'(0));
    drain();

    // Back-to-back hub commands with the thread unit always ready
    launch_ready = 1'b1;
    start_cyc  = cyc;
    start_acks = acks;
    for (int k = 0; k < 8; k++) send(14'h200 + 14'(k), 32'hB0B00000 + 32'(k));
    chk("t5_cycles_le16", 64'((cyc - start_cyc) <= 16), 64'(1));
    tick();
    launch_ready = 1'b0;
    chk("t5_acks",  64'(acks - start_acks), 64'(8));
    chk("t5_empty", 64'(launch_valid),      64'(0));

    // Asynchronous reset with three queued entries and ack high
    send(14'h1, 32'h11);
    send(14'h2, 32'h22);
    send(14'h3, 32'h33);
    chk("t6_pre_level", 64'(rx_level), 64'(3));
    #2 rstn = 1'b0;
    #1;
    chk("t6_ack",   64'(mp_access_ack), 64'(0));
    chk("t6_valid", 64'(launch_valid),  64'(0));
    chk("t6_level", 64'(rx_level),      64'(0));
    chk("t6_full",  64'(rx_full),       64'(0));
    chk("t6_pc",    64'(launch_pc),     64'(0));
    chk("t6_data",  64'(launch_data),   64'(0));
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    chk("t6_post_valid", 64'(launch_valid), 64'(0));
    send(14'h77, 32'h7777);
    chk("t6_new_level", 64'(rx_level),  64'(1));
    chk("t6_new_pc",    64'(launch_pc), 64'h77);
    tick();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
